fir5_decoder: RTL and testbench

FIR5_DECODER -- requirements
Module: fir5_decoder

---
 rtl/fir5_decoder.sv | 127 ++++++++++++
 tb/tb_fir5_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir5_decoder.sv
// fir5_decoder: recovers x[n] from the 5-tap FIR code
//   y = 2*x[n] + C1*x[n-1] + C2*x[n-2] + C3*x[n-3] + C4*x[n-4]  (mod 256)
// by subtracting the weighted history one tap per cycle. What remains
// must equal 2*x[n]. Any residue that is odd or exceeds 5 bits marks a
// non-codeword.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds data and valid until that edge. The
// DUT raises ready only when it can take the word. There is no skid
// buffer: y_ready is high only in IDLE, and x_valid is high only in OUT.
module fir5_decoder #(
  parameter int C1 = 3,
  parameter int C2 = 2,
  parameter int C3 = 5,
  parameter int C4 = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [7:0] y_in,
  input  logic       y_valid,
  output logic       y_ready,
  output logic [3:0] x_out,
  output logic       x_valid,
  input  logic       x_ready,
  output logic       sym_err,
  output logic       err_sticky,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_CHK  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] acc;
  logic [1:0] k;
  logic [3:0] hist [4];   // hist[0] = x[n-1] ... hist[3] = x[n-4]

  logic [7:0] tap_prod;
  logic [3:0] x_new;
  logic       err_new;

  // Weighted history term for the tap currently being removed, kept at 8 bits.
  always_comb begin
    tap_prod = 8'd0;
    case (k)
      2'd0: tap_prod = 8'(C1) * {4'd0, hist[0]};
      2'd1: tap_prod = 8'(C2) * {4'd0, hist[1]};
      2'd2: tap_prod = 8'(C3) * {4'd0, hist[2]};
      2'd3: tap_prod = 8'(C4) * {4'd0, hist[3]};
      default: tap_prod = 8'd0;
    endcase
  end

  // The residue after all taps is 2*x[n] for a valid codeword.
  always_comb begin
    x_new   = acc[4:1];
    err_new = acc[0] | (acc[7:5] != 3'd0);
  end

  assign y_ready   = (state == S_IDLE);
  assign x_valid   = (state == S_OUT);
  assign state_dbg = state;

  // Decoder FSM: accept, subtract four taps, check, hold the result until it is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      acc        <= 8'd0;
      k          <= 2'd0;
      hist[0]    <= 4'd0;
      hist[1]    <= 4'd0;
      hist[2]    <= 4'd0;
      hist[3]    <= 4'd0;
      x_out      <= 4'd0;
      sym_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else if (flush) begin
      // flush wins over any handshake on the same edge
      state      <= S_IDLE;
      acc        <= 8'd0;
      k          <= 2'd0;
      hist[0]    <= 4'd0;
      hist[1]    <= 4'd0;
      hist[2]    <= 4'd0;
      hist[3]    <= 4'd0;
      x_out      <= 4'd0;
      sym_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (y_valid) begin
            acc   <= y_in;
            k     <= 2'd0;
            state <= S_SUB;
          end
        end
        S_SUB: begin
          acc <= acc - tap_prod;
          k   <= k + 2'd1;
          if (k == 2'd3) state <= S_CHK;
        end
        S_CHK: begin
          x_out      <= x_new;
          sym_err    <= err_new;
          err_sticky <= err_sticky | err_new;
          // history advances even on a bad symbol so the stream stays aligned
          hist[0]    <= x_new;
          hist[1]    <= hist[0];
          hist[2]    <= hist[1];
          hist[3]    <= hist[2];
          state      <= S_OUT;
        end
        S_OUT: begin
          if (x_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir5_decoder.sv
// Directed bench for fir5_decoder with a queue-based scoreboard.
module tb_fir5_decoder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] y_in;
  logic       y_valid;
  logic       y_ready;
  logic [3:0] x_out;
  logic       x_valid;
  logic       x_ready;
  logic       sym_err;
  logic       err_sticky;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  fir5_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .sym_err    (sym_err),
    .err_sticky (err_sticky),
    .state_dbg  (state_dbg)
  );

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;

  int checks   = 0;
  int failures = 0;

  // expected {sym_err, x_out}
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && x_valid && x_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got x=%0d err=%0d expected none", x_out, sym_err);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({sym_err, x_out} != e) begin
          failures++;
          $display("FAIL output: got x=%0d err=%0d expected x=%0d err=%0d",
                   x_out, sym_err, e[3:0], e[4]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer y; returns at #1 after the accepting edge. push selects scoreboarding.
  task automatic send(input logic [7:0] y, input logic push,
                      input logic [3:0] ex, input logic ee);
    int n;
    if (push) exp_q.push_back({ee, ex});
    y_in    = y;
    y_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!y_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no y_ready expected y_ready=1");
    end
    @(posedge clk);
    #1;
    y_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    rst = 1'b0; flush = 1'b0; y_in = 8'd33; y_valid = 1'b1; x_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y_ready", y_ready, 1);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_sym_err", sym_err, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_no_transfer", state_dbg, ST_IDLE);
    y_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single sample and latency
    send(8'd10, 1'b1, 4'd5, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (x_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 5);
    drain();

    // stream continuing from x=5 history
    do_flush();
    send(8'd10, 1'b1, 4'd5, 1'b0);
    send(8'd17, 1'b1, 4'd1, 1'b0);
    send(8'd15, 1'b1, 4'd1, 1'b0);
    send(8'd32, 1'b1, 4'd1, 1'b0);
    send(8'd42, 1'b1, 4'd1, 1'b0);
    send(8'd18, 1'b1, 4'd1, 1'b0);
    drain();
    chk("stream_err_sticky", err_sticky, 0);

    // wrap-around stream
    do_flush();
    send(8'd30,  1'b1, 4'd15, 1'b0);
    send(8'd75,  1'b1, 4'd15, 1'b0);
    send(8'd105, 1'b1, 4'd15, 1'b0);
    send(8'd180, 1'b1, 4'd15, 1'b0);
    send(8'd14,  1'b1, 4'd15, 1'b0);
    drain();

    // error symbols
    do_flush();
    send(8'd11, 1'b1, 4'd5, 1'b1);
    drain();
    chk("err_sticky_set", err_sticky, 1);
    do_flush();
    chk("flush_clears_sticky", err_sticky, 0);
    send(8'd64, 1'b1, 4'd0, 1'b1);
    drain();
    chk("err_sticky_set2", err_sticky, 1);
    do_flush();
    chk("flush_clears_sticky2", err_sticky, 0);

    // backpressure
    x_ready = 1'b0;
    send(8'd10, 1'b1, 4'd5, 1'b0);
    lat = 0;
    while (!x_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_x_valid", x_valid, 1);
    y_in = 8'd99; y_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_x_out_stable", x_out, 5);
      chk("bp_sym_err_stable", sym_err, 0);
      chk("bp_y_ready_low", y_ready, 0);
      chk("bp_x_valid_held", x_valid, 1);
    end
    // 99 - 3*5 = 84 -> x=10, residue bits 7:5 nonzero
    exp_q.push_back({1'b1, 4'd10});
    x_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_back_to_idle", state_dbg, ST_IDLE);
    @(posedge clk);
    #1;
    chk("bp_pending_accepted", state_dbg, ST_SUB);
    y_valid = 1'b0;
    drain();

    // flush abort in the second SUB cycle, with nonzero history primed
    do_flush();
    send(8'd10, 1'b1, 4'd5, 1'b0);
    drain();
    send(8'd17, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_abort_idle", state_dbg, ST_IDLE);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_abort_no_valid", x_valid, 0);
    send(8'd10, 1'b1, 4'd5, 1'b0);
    drain();

    // reset pulse during CHK, with nonzero history primed
    send(8'd17, 1'b1, 4'd1, 1'b0);
    drain();
    send(8'd15, 1'b0, 4'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_abort_y_ready", y_ready, 1);
    chk("rst_abort_x_valid", x_valid, 0);
    #2 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_abort_no_valid", x_valid, 0);
    send(8'd10, 1'b1, 4'd5, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
